// File: rtl/ctnr_down_timer_if.sv
// Host-side bus of the down-counting timer: load/tick/snapshot controls and count/status returns.
// CTNR_PRESCALE_EN adds the PSC prescale-divisor field.
interface ctnr_down_timer_if #(
    parameter int WIDTH = 16
`ifdef CTNR_PRESCALE_EN
    , parameter int PSW = 4
`endif
);
    logic             LD;
    logic [WIDTH-1:0] D;
    logic             MODE;
    logic             ENAB;
    logic             RDLAT;
    logic             IRQACK;
`ifdef CTNR_PRESCALE_EN
    logic [PSW-1:0]   PSC;
`endif
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] LATQ;
    logic             TC;
    logic             IRQ;
    logic             RUN;

    modport master (
        output LD, D, MODE, ENAB, RDLAT, IRQACK,
        input  Q, LATQ, TC, IRQ, RUN
`ifdef CTNR_PRESCALE_EN
        , output PSC
`endif
    );

    modport slave (
        input  LD, D, MODE, ENAB, RDLAT, IRQACK,
        output Q, LATQ, TC, IRQ, RUN
`ifdef CTNR_PRESCALE_EN
        , input PSC
`endif
    );
endinterface

// File: rtl/ctnr_down_timer.sv
// Loadable down-counting timer with one-shot/auto-reload, sticky IRQ and a snapshot latch.
// Optional ENAB prescaler is compiled in with CTNR_PRESCALE_EN.
module ctnr_down_timer #(
    parameter int WIDTH = 16
`ifdef CTNR_PRESCALE_EN
    , parameter int PSW = 4
`endif
) (
    input  logic                 MasterClock,
    input  logic                 RESETL,
    ctnr_down_timer_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_latq;
    logic             r_tc;
    logic             r_irq;
    logic             r_run;

    logic             w_tick;
    logic             w_terminal;

`ifdef CTNR_PRESCALE_EN
    logic [PSW-1:0]   r_psc;
    logic [PSW-1:0]   r_pscCount;
    logic             w_pscWrap;

    assign w_pscWrap = (r_pscCount == r_psc);
    assign w_tick    = bus.ENAB && w_pscWrap;

    // Counts ENAB pulses only while armed; a load restarts the divide sequence.
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_psc      <= '0;
            r_pscCount <= '0;
        end else if (bus.LD) begin
            r_psc      <= bus.PSC;
            r_pscCount <= '0;
        end else if (r_state == ARMED && bus.ENAB) begin
            r_pscCount <= w_pscWrap ? '0 : r_pscCount + PSW'(1);
        end
    end
`else
    assign w_tick = bus.ENAB;
`endif

    // Load takes priority, so a tick (and its terminal count) in a load cycle is discarded.
    assign w_terminal = !bus.LD && (r_state == ARMED) && w_tick && (r_q <= WIDTH'(1));

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_latq   <= '0;
            r_tc     <= 1'b0;
            r_irq    <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_tc <= w_terminal;
            if (bus.RDLAT) begin
                r_latq <= r_q;
            end
            if (bus.LD) begin
                r_reload <= bus.D;
                r_q      <= bus.D;
                if (bus.D != '0) begin
                    r_state <= ARMED;
                    r_run   <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_run   <= 1'b0;
                end
            end else if (r_state == ARMED && w_tick) begin
                if (!w_terminal) begin
                    r_q <= r_q - WIDTH'(1);
                end else if (bus.MODE) begin
                    r_q <= r_reload;
                end else begin
                    r_q     <= '0;
                    r_state <= IDLE;
                    r_run   <= 1'b0;
                end
            end
            // A terminal count outranks a same-edge acknowledge.
            if (w_terminal) begin
                r_irq <= 1'b1;
            end else if (bus.IRQACK) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.LATQ = r_latq;
    assign bus.TC   = r_tc;
    assign bus.IRQ  = r_irq;
    assign bus.RUN  = r_run;

endmodule

// File: tb/tb_ctnr_down_timer.sv
// Self-checking bench for ctnr_down_timer: directed vector table, corner sequences, and
// randomized traffic against a behavioural model (honours CTNR_PRESCALE_EN when defined).
module tb_ctnr_down_timer;

    logic MasterClock = 1'b0;
    logic RESETL      = 1'b0;

    always #5 MasterClock = ~MasterClock;

`ifdef CTNR_PRESCALE_EN
    ctnr_down_timer_if #(.WIDTH(16), .PSW(4)) bus ();
    ctnr_down_timer #(.WIDTH(16), .PSW(4)) dut (
        .MasterClock (MasterClock),
        .RESETL      (RESETL),
        .bus         (bus)
    );
`else
    ctnr_down_timer_if #(.WIDTH(16)) bus ();
    ctnr_down_timer #(.WIDTH(16)) dut (
        .MasterClock (MasterClock),
        .RESETL      (RESETL),
        .bus         (bus)
    );
`endif

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic        mode;
        logic        enab;
        logic        rdlat;
        logic        irqack;
        logic [15:0] q;
        logic [15:0] latq;
        logic        tc;
        logic        irq;
        logic        run;
    } vec_t;

    vec_t vecs[$];
    int   nTotal = 0;
    int   nBad   = 0;
    logic [3:0] stimPsc = 4'd0;

    // Behavioural reference state.
    logic [15:0] mQ, mReload, mLatq;
    logic        mArmed, mTc, mIrq;
    int          mPsc, mPulses;

    function automatic vec_t mk(input logic ld, input logic [15:0] d, input logic mode,
                                input logic enab, input logic rdlat, input logic irqack,
                                input logic [15:0] q, input logic [15:0] latq,
                                input logic tc, input logic irq, input logic run);
        vec_t v;
        v.ld = ld; v.d = d; v.mode = mode; v.enab = enab; v.rdlat = rdlat; v.irqack = irqack;
        v.q = q; v.latq = latq; v.tc = tc; v.irq = irq; v.run = run;
        return v;
    endfunction

    task automatic cmpField(input string tag, input string field,
                            input logic [15:0] act, input logic [15:0] exp);
        nTotal++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s %s actual=%0d required=%0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] q, input logic [15:0] latq,
                               input logic tc, input logic irq, input logic run);
        cmpField(tag, "Q",    bus.Q,            q);
        cmpField(tag, "LATQ", bus.LATQ,         latq);
        cmpField(tag, "TC",   {15'd0, bus.TC},  {15'd0, tc});
        cmpField(tag, "IRQ",  {15'd0, bus.IRQ}, {15'd0, irq});
        cmpField(tag, "RUN",  {15'd0, bus.RUN}, {15'd0, run});
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic mode,
                                 input logic enab, input logic rdlat, input logic irqack);
        bus.LD = ld; bus.D = d; bus.MODE = mode;
        bus.ENAB = enab; bus.RDLAT = rdlat; bus.IRQACK = irqack;
`ifdef CTNR_PRESCALE_EN
        bus.PSC = stimPsc;
`endif
        @(posedge MasterClock);
        #1;
    endtask

    task automatic modelReset();
        mQ = 0; mReload = 0; mLatq = 0; mArmed = 0; mTc = 0; mIrq = 0;
        mPsc = 0; mPulses = 0;
    endtask

    // Next-state of the timer from its rules; uses pre-edge values throughout.
    task automatic modelStep(input logic ld, input logic [15:0] d, input logic mode,
                             input logic enab, input logic rdlat, input logic irqack,
                             input int psc);
        bit tick;
        if (rdlat) mLatq = mQ;
        mTc = 0;
        if (ld) begin
            mReload = d;
            mQ      = d;
            mArmed  = (d != 0);
            mPulses = 0;
`ifdef CTNR_PRESCALE_EN
            mPsc    = psc;
`endif
        end else if (mArmed && enab) begin
`ifdef CTNR_PRESCALE_EN
            mPulses = mPulses + 1;
            tick    = (mPulses == mPsc + 1);
            if (tick) mPulses = 0;
`else
            tick    = 1;
`endif
            if (tick) begin
                if (mQ == 1) begin
                    mTc = 1;
                    if (mode) mQ = mReload;
                    else begin
                        mQ     = 0;
                        mArmed = 0;
                    end
                end else begin
                    mQ = mQ - 1;
                end
            end
        end
        if (mTc) mIrq = 1;
        else if (irqack) mIrq = 0;
    endtask

    task automatic doReset();
        RESETL = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        RESETL = 1'b1;
        modelReset();
    endtask

    initial begin
        bus.LD = 0; bus.D = 0; bus.MODE = 0; bus.ENAB = 0; bus.RDLAT = 0; bus.IRQACK = 0;
`ifdef CTNR_PRESCALE_EN
        bus.PSC = 0;
`endif
        //           ld d   m  en rl ack   Q   LATQ tc irq run
        vecs.push_back(mk(1, 5, 0, 0, 0, 0,  5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0,  3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  3, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1,  3, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1,  3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  3, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1,  3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 7, 0, 1, 0, 0,  7, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  3, 4, 0, 0, 1));
        vecs.push_back(mk(1, 9, 0, 0, 1, 0,  9, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  9, 3, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,  1, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  0, 3, 0, 1, 0));

        #1;
        checkOutput("reset_async", 0, 0, 0, 0, 0);
        doReset();
        checkOutput("reset", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].mode,
                          vecs[i].enab, vecs[i].rdlat, vecs[i].irqack);
            checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].latq,
                        vecs[i].tc, vecs[i].irq, vecs[i].run);
        end

        // Reset dropped while TC and IRQ are high and LATQ holds a snapshot.
        doReset();
        applyStimulus(1, 2, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("pre_reset", 2, 1, 1, 1, 1);
        #2;
        RESETL = 1'b0;
        #1;
        checkOutput("mid_reset", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("held_reset", 0, 0, 0, 0, 0);
        RESETL = 1'b1;

`ifdef CTNR_PRESCALE_EN
        stimPsc = 4'd2;
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("psc_load", 2, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p1", 2, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p2", 2, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p3", 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p4", 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p5", 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("psc_p6", 0, 0, 1, 1, 0);
`endif

        doReset();
        for (int n = 0; n < 800; n++) begin
            logic        ld, mode, enab, rdlat, irqack;
            logic [15:0] d;
            ld     = ($urandom_range(0, 9) == 0);
            d      = 16'($urandom_range(0, 5));
            mode   = 1'($urandom_range(0, 1));
            enab   = ($urandom_range(0, 3) != 0);
            rdlat  = ($urandom_range(0, 4) == 0);
            irqack = ($urandom_range(0, 5) == 0);
            stimPsc = 4'($urandom_range(0, 2));
            modelStep(ld, d, mode, enab, rdlat, irqack, int'(stimPsc));
            applyStimulus(ld, d, mode, enab, rdlat, irqack);
            checkOutput($sformatf("rand%0d", n), mQ, mLatq, mTc, mIrq, mArmed);
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
